dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Shares the single synchronous-read DMEM port between two requesters: the pipeline MEM-stage LSU (primary) and an external loader/debug master (secondary). The LSU normally wins, but a bounded-wait guard forces a grant to the external port after it has waited a configured number of cycles. Sits between `stage_mem` and the `dmem` instance. It routes the one-cycle-late read data back to whichever port issued the read.

## Interface
- `MAX_WAIT`, default 8: cycles the external port may wait before a forced grant; legal range 1..255.
- `ADDR_W`, default 16: DMEM byte-address width.

Ports:
- `i_clk` in 1: the only clock; all state updates on its rising edge.
- `i_reset` in 1: synchronous, active-low reset.
- `i_lsu_req` in 1: LSU access request; already gated by valid, not-bubble and not-kill.
- `i_lsu_we` in 1: 1 = write, 0 = read.
- `i_lsu_be` in 4: write byte enables, already aligned to the lane.
- `i_lsu_addr` in ADDR_W: byte address; bits [1:0] ignored.
- `i_lsu_wdata` in 32: write data, lane-replicated.
- `o_lsu_stall` in the out direction, 1: LSU request present but not granted this cycle.
- `o_lsu_rvalid` out 1: read data for the LSU is valid this cycle.
- `o_lsu_rdata` out 32: LSU read data.
- `i_ext_req`, `i_ext_we`, `i_ext_be`[4], `i_ext_addr`[ADDR_W], `i_ext_wdata`[32] in: external request; same meaning as the LSU inputs.
- `o_ext_gnt` out 1: external request accepted this cycle.
- `o_ext_rvalid` out 1: read data for the external port is valid this cycle.
- `o_ext_rdata` out 32: external read data.
- `o_dmem_addr` out ADDR_W: word-aligned address to DMEM, low 2 bits = 0.
- `o_dmem_wdata` out 32: write data to DMEM.
- `o_dmem_wren` out 4: byte write enables to DMEM.
- `i_dmem_q` in 32: DMEM read data, valid one cycle after the address.

## Operation
- Grant decision is combinational within the cycle:
  - `lsu_win = i_lsu_req & ~(state==S_FORCE & i_ext_req)`
  - `ext_win = i_ext_req & ~lsu_win`
- `o_ext_gnt = ext_win`.
- `o_lsu_stall = i_lsu_req & ~lsu_win`.
- DMEM mux:
  - `o_dmem_addr` = winner's address with bits [1:0] forced to 0; 0 when there is no winner.
  - `o_dmem_wdata` = winner's write data.
  - `o_dmem_wren` = winner's `be` when winner's `we`=1, else 4'b0000.
- Writes with `we`=1 and `be`=0000 are granted as no-ops and return no rvalid.
- Read owner register `rd_own` takes one of NONE, LSU, EXT. It captures the winner of a granted read (`we`=0); otherwise it is NONE.
- `o_lsu_rvalid = (rd_own==LSU)` and `o_ext_rvalid = (rd_own==EXT)`.
- Each `o_*_rdata` = `i_dmem_q` when its rvalid is high, else 0.
- Wait counter `wcnt` (8 bits):
  - increments, saturating at MAX_WAIT, on each cycle with `i_ext_req & ~ext_win`;
  - clears on `ext_win` or when `i_ext_req` = 0.
- FSM:
  - S_NORMAL -> S_FORCE when the next `wcnt` value equals MAX_WAIT.
  - S_FORCE -> S_NORMAL on `ext_win` or when `i_ext_req` drops.
- Handshake: the external master must hold req/we/be/addr/wdata stable until `o_ext_gnt`. Dropping req before grant is legal and abandons the request.
- The LSU holds its inputs while `o_lsu_stall`=1; the pipeline freezes the EX/MEM register on this signal.

## Timing
- Reset values:
  - state S_NORMAL, `wcnt`=0, `rd_own`=NONE;
  - `o_lsu_rvalid`/`o_ext_rvalid`=0 and both rdata=0;
  - with no requests present: `o_dmem_wren`=0, `o_dmem_addr`=0, `o_ext_gnt`=0, `o_lsu_stall`=0.
- Write latency: data is committed at the edge that ends the grant cycle.
- Read latency: rvalid and rdata appear exactly 1 cycle after the grant cycle. Back-to-back reads can be granted every cycle, to either port.
- Both ports requesting in S_NORMAL: LSU wins and `wcnt` increments.
- In S_FORCE with both requesting: EXT wins and `o_lsu_stall`=1 for that one cycle only.
- With MAX_WAIT=1: EXT is forced on the second contended cycle.
- Reset asserted mid-read: the pending rvalid is cancelled. No rvalid appears in the cycle after reset release.
- In S_FORCE with no LSU request: EXT is granted normally.

## Configuration
- `DMEM_ARB_STARVE_EN` defined: wait counter and S_FORCE behaviour as above.
- `DMEM_ARB_STARVE_EN` undefined:
  - strict LSU priority; the FSM stays in S_NORMAL and `wcnt` is not built;
  - `lsu_win = i_lsu_req`;
  - the external port can starve indefinitely.

## Structure
- Shared package `dmem_arb_pkg`:
  - `arb_state_t` enum {S_NORMAL, S_FORCE};
  - `rd_owner_t` enum {NONE, LSU, EXT};
  - `DMEM_ARB_MAX_WAIT_DEF`=8.
- One sub-module `dmem_arb_starve_ctr`: the saturating wait counter plus the FSM; it outputs `force`. Instantiated only under `DMEM_ARB_STARVE_EN`.

## Test plan
- After reset, a lone LSU write to addr 0x0010 with be=1111 and data 0xDEADBEEF -> `o_dmem_wren`=1111 and `o_dmem_addr`=0x0010 in the same cycle; an LSU read of 0x0010 -> `o_lsu_rvalid`=1 with 0xDEADBEEF one cycle later.
- LSU and EXT both reading continuously, MAX_WAIT=8 -> EXT granted on the 9th contended cycle; `o_lsu_stall`=1 in exactly that cycle; `wcnt` returns to 0.
- Macro undefined, same stimulus for 50 cycles -> `o_ext_gnt` never asserts and `o_lsu_stall` stays 0.
- Alternating LSU and EXT reads of 0x0100 and 0x0200 in consecutive cycles -> each rvalid goes only to the issuer, with the correct data, one cycle later; no cross-delivery.
- EXT holds req for 3 contended cycles and then drops it -> `wcnt` clears and the FSM stays or returns to S_NORMAL; no grant.
- EXT read granted, then `i_reset`=0 on the next edge -> `o_ext_rvalid`=0 and `o_ext_rdata`=0 after that edge.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// dmem_arb_pkg: shared types and defaults for the DMEM port arbiter.
package dmem_arb_pkg;
    typedef enum logic {S_NORMAL, S_FORCE} arb_state_t;
    typedef enum logic [1:0] {NONE, LSU, EXT} rd_owner_t;
    localparam int DMEM_ARB_MAX_WAIT_DEF = 8;
endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: LSU, external-master and DMEM signals of the arbiter.
interface dmem_arbiter_if #(parameter int ADDR_W = 16);
    logic              i_lsu_req;
    logic              i_lsu_we;
    logic [3:0]        i_lsu_be;
    logic [ADDR_W-1:0] i_lsu_addr;
    logic [31:0]       i_lsu_wdata;
    logic              o_lsu_stall;
    logic              o_lsu_rvalid;
    logic [31:0]       o_lsu_rdata;
    logic              i_ext_req;
    logic              i_ext_we;
    logic [3:0]        i_ext_be;
    logic [ADDR_W-1:0] i_ext_addr;
    logic [31:0]       i_ext_wdata;
    logic              o_ext_gnt;
    logic              o_ext_rvalid;
    logic [31:0]       o_ext_rdata;
    logic [ADDR_W-1:0] o_dmem_addr;
    logic [31:0]       o_dmem_wdata;
    logic [3:0]        o_dmem_wren;
    logic [31:0]       i_dmem_q;
    modport slave (
        input  i_lsu_req, i_lsu_we, i_lsu_be, i_lsu_addr, i_lsu_wdata,
        input  i_ext_req, i_ext_we, i_ext_be, i_ext_addr, i_ext_wdata, i_dmem_q,
        output o_lsu_stall, o_lsu_rvalid, o_lsu_rdata,
        output o_ext_gnt, o_ext_rvalid, o_ext_rdata,
        output o_dmem_addr, o_dmem_wdata, o_dmem_wren
    );
    modport master (
        output i_lsu_req, i_lsu_we, i_lsu_be, i_lsu_addr, i_lsu_wdata,
        output i_ext_req, i_ext_we, i_ext_be, i_ext_addr, i_ext_wdata, i_dmem_q,
        input  o_lsu_stall, o_lsu_rvalid, o_lsu_rdata,
        input  o_ext_gnt, o_ext_rvalid, o_ext_rdata,
        input  o_dmem_addr, o_dmem_wdata, o_dmem_wren
    );
endinterface

// File: rtl/dmem_arb_starve_ctr.sv
// dmem_arb_starve_ctr: saturating external-wait counter and force FSM;
// o_force is high in S_FORCE, where a waiting external request beats the LSU.
module dmem_arb_starve_ctr
    import dmem_arb_pkg::*;
#(
    parameter int MAX_WAIT = DMEM_ARB_MAX_WAIT_DEF
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_ext_req,
    input  logic i_ext_win,
    output logic o_force
);
    localparam logic [7:0] WMAX = 8'(MAX_WAIT);
    arb_state_t state_q;
    logic [7:0] wcnt_q, wcnt_d;
    always_comb wcnt_d = (!i_ext_req || i_ext_win) ? 8'd0 : (wcnt_q == WMAX) ? WMAX : wcnt_q + 8'd1;
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state_q <= S_NORMAL;
            wcnt_q  <= 8'd0;
        end else begin
            wcnt_q <= wcnt_d;
            case (state_q)
                S_NORMAL: if (wcnt_d == WMAX) state_q <= S_FORCE;
                S_FORCE:  if (i_ext_win || !i_ext_req) state_q <= S_NORMAL;
                default:  state_q <= S_NORMAL;
            endcase
        end
    end
    assign o_force = (state_q == S_FORCE);
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the synchronous-read DMEM port between the LSU and an external master.
// Define DMEM_ARB_STARVE_EN to enable the bounded-wait forced grant for the external port.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int MAX_WAIT = DMEM_ARB_MAX_WAIT_DEF,
    parameter int ADDR_W   = 16
) (
    input  logic i_clk,
    input  logic i_reset,
    dmem_arbiter_if.slave bus
);
    logic force_ext, lsu_win, ext_win;
    logic [ADDR_W-1:0] addr_sel;
    rd_owner_t rd_own_q, rd_own_d;
    if (MAX_WAIT < 1 || MAX_WAIT > 255) begin : g_bad_max_wait
        $error("dmem_arbiter: MAX_WAIT must be within 1..255");
    end
`ifdef DMEM_ARB_STARVE_EN
    dmem_arb_starve_ctr #(.MAX_WAIT(MAX_WAIT)) u_starve (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_ext_req (bus.i_ext_req),
        .i_ext_win (ext_win),
        .o_force   (force_ext)
    );
`else
    assign force_ext = 1'b0;
`endif
    always_comb begin
        lsu_win  = bus.i_lsu_req & ~(force_ext & bus.i_ext_req);
        ext_win  = bus.i_ext_req & ~lsu_win;
        addr_sel = lsu_win ? bus.i_lsu_addr : ext_win ? bus.i_ext_addr : '0;
        rd_own_d = (lsu_win & ~bus.i_lsu_we) ? LSU : (ext_win & ~bus.i_ext_we) ? EXT : NONE;
    end
    assign bus.o_ext_gnt    = ext_win;
    assign bus.o_lsu_stall  = bus.i_lsu_req & ~lsu_win;
    assign bus.o_dmem_addr  = addr_sel & ~ADDR_W'(3);
    assign bus.o_dmem_wdata = lsu_win ? bus.i_lsu_wdata : bus.i_ext_wdata;
    assign bus.o_dmem_wren  = (lsu_win & bus.i_lsu_we) ? bus.i_lsu_be :
                              (ext_win & bus.i_ext_we) ? bus.i_ext_be : 4'b0000;
    // Read data returns one cycle after the grant; the owner register steers it.
    always_ff @(posedge i_clk) begin
        rd_own_q <= !i_reset ? NONE : rd_own_d;
    end
    assign bus.o_lsu_rvalid = (rd_own_q == LSU);
    assign bus.o_ext_rvalid = (rd_own_q == EXT);
    assign bus.o_lsu_rdata  = bus.o_lsu_rvalid ? bus.i_dmem_q : 32'h0;
    assign bus.o_ext_rdata  = bus.o_ext_rvalid ? bus.i_dmem_q : 32'h0;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scoreboard bench for dmem_arbiter with a DMEM model.
// Checks the starvation guard when DMEM_ARB_STARVE_EN is defined, strict priority otherwise.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;
    localparam int AW = 16;
    typedef struct packed {
        logic          req;
        logic          we;
        logic [3:0]    be;
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
    } req_t;
    typedef struct {
        rd_owner_t   own;
        logic [31:0] data;
    } exp_t;
    localparam req_t IDLE = '0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_cmp = 0;
    int n_err = 0;
    exp_t sb[$];
    logic [31:0] mem [0:(1<<(AW-2))-1];
    logic [31:0] ref_mem [int];

    dmem_arbiter_if #(.ADDR_W(AW)) bus();
    dmem_arbiter #(.MAX_WAIT(8), .ADDR_W(AW)) dut (
        .i_clk   (clk),
        .i_reset (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (bus.o_dmem_wren[b]) mem[bus.o_dmem_addr[AW-1:2]][8*b +: 8] <= bus.o_dmem_wdata[8*b +: 8];
        bus.i_dmem_q <= mem[bus.o_dmem_addr[AW-1:2]];
    end

    function automatic logic [31:0] ref_word(int idx);
        return ref_mem.exists(idx) ? ref_mem[idx] : (32'hA5A5_0000 | 32'(idx));
    endfunction

    function automatic req_t rd(logic [AW-1:0] a);
        req_t r = '0;
        r.req = 1'b1; r.addr = a;
        return r;
    endfunction

    function automatic req_t wr(logic [AW-1:0] a, logic [3:0] be, logic [31:0] d);
        req_t r;
        r.req = 1'b1; r.we = 1'b1; r.be = be; r.addr = a; r.wdata = d;
        return r;
    endfunction

    task automatic drive(req_t l, req_t e);
        bus.i_lsu_req = l.req; bus.i_lsu_we = l.we; bus.i_lsu_be = l.be;
        bus.i_lsu_addr = l.addr; bus.i_lsu_wdata = l.wdata;
        bus.i_ext_req = e.req; bus.i_ext_we = e.we; bus.i_ext_be = e.be;
        bus.i_ext_addr = e.addr; bus.i_ext_wdata = e.wdata;
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One cycle: drive after the edge, check at the falling edge, queue the read return.
    task automatic step(string tag, logic rn, req_t l, req_t e, logic exp_gnt, logic exp_stall);
        exp_t x;
        req_t w;
        logic lw, ew;
        logic [31:0] cur;
        int idx;
        @(posedge clk);
        #1;
        rst_n = rn;
        drive(l, e);
        @(negedge clk);
        x.own = NONE; x.data = 32'h0;
        if (sb.size() != 0) x = sb.pop_front();
        chk({tag, " lsu_rvalid"}, 32'(bus.o_lsu_rvalid), 32'(x.own == LSU));
        chk({tag, " ext_rvalid"}, 32'(bus.o_ext_rvalid), 32'(x.own == EXT));
        chk({tag, " lsu_rdata"}, bus.o_lsu_rdata, (x.own == LSU) ? x.data : 32'h0);
        chk({tag, " ext_rdata"}, bus.o_ext_rdata, (x.own == EXT) ? x.data : 32'h0);
        chk({tag, " ext_gnt"}, 32'(bus.o_ext_gnt), 32'(exp_gnt));
        chk({tag, " lsu_stall"}, 32'(bus.o_lsu_stall), 32'(exp_stall));
        lw = l.req & ~exp_stall;
        ew = exp_gnt;
        w = lw ? l : ew ? e : IDLE;
        idx = int'(w.addr[AW-1:2]);
        chk({tag, " dmem_addr"}, 32'(bus.o_dmem_addr), (lw | ew) ? 32'({w.addr[AW-1:2], 2'b00}) : 32'h0);
        chk({tag, " dmem_wren"}, 32'(bus.o_dmem_wren), w.we ? 32'(w.be) : 32'h0);
        if (w.we) chk({tag, " dmem_wdata"}, bus.o_dmem_wdata, w.wdata);
        if (w.req && w.we) begin
            cur = ref_word(idx);
            for (int b = 0; b < 4; b++) if (w.be[b]) cur[8*b +: 8] = w.wdata[8*b +: 8];
            ref_mem[idx] = cur;
        end
        x.own = NONE; x.data = 32'h0;
        if (rn && w.req && !w.we) begin
            x.own = lw ? LSU : EXT;
            x.data = ref_word(idx);
        end
        sb.push_back(x);
    endtask

    initial begin
        exp_t x0;
        for (int i = 0; i < (1 << (AW - 2)); i++) mem[i] = 32'hA5A5_0000 | 32'(i);
        drive(IDLE, IDLE);
        x0.own = NONE; x0.data = 32'h0;
        sb.push_back(x0);
        step("rst0", 1'b0, IDLE, IDLE, 1'b0, 1'b0);
        step("rst1", 1'b0, IDLE, IDLE, 1'b0, 1'b0);
        step("idle", 1'b1, IDLE, IDLE, 1'b0, 1'b0);
        step("lsu_wr", 1'b1, wr(16'h0010, 4'hF, 32'hDEADBEEF), IDLE, 1'b0, 1'b0);
        step("lsu_rd", 1'b1, rd(16'h0010), IDLE, 1'b0, 1'b0);
        step("lsu_rd_ret", 1'b1, IDLE, IDLE, 1'b0, 1'b0);
        step("ext_wr", 1'b1, IDLE, wr(16'h0200, 4'hF, 32'h12345678), 1'b1, 1'b0);
        step("lsu_wr_part", 1'b1, wr(16'h0100, 4'h3, 32'hCAFEF00D), IDLE, 1'b0, 1'b0);
        step("alt0", 1'b1, rd(16'h0100), IDLE, 1'b0, 1'b0);
        step("alt1", 1'b1, IDLE, rd(16'h0200), 1'b1, 1'b0);
        step("alt2", 1'b1, rd(16'h0102), IDLE, 1'b0, 1'b0);
        step("alt3", 1'b1, IDLE, rd(16'h0203), 1'b1, 1'b0);
        step("alt_ret", 1'b1, IDLE, IDLE, 1'b0, 1'b0);
        step("ext_nop_wr", 1'b1, IDLE, wr(16'h0300, 4'h0, 32'hFFFFFFFF), 1'b1, 1'b0);
        step("nop_ret", 1'b1, IDLE, IDLE, 1'b0, 1'b0);
        step("both_wr", 1'b1, wr(16'h0104, 4'hC, 32'h55AA55AA), rd(16'h0200), 1'b0, 1'b0);
        step("both_wr_chk", 1'b1, rd(16'h0104), IDLE, 1'b0, 1'b0);
        step("both_wr_ret", 1'b1, IDLE, IDLE, 1'b0, 1'b0);
`ifdef DMEM_ARB_STARVE_EN
        for (int i = 0; i < 8; i++) step("force_wait", 1'b1, rd(16'h0010), rd(16'h0200), 1'b0, 1'b0);
        step("force_gnt", 1'b1, rd(16'h0010), rd(16'h0200), 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step("drop_wait", 1'b1, rd(16'h0010), rd(16'h0204), 1'b0, 1'b0);
        step("drop", 1'b1, rd(16'h0010), IDLE, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step("rewait", 1'b1, rd(16'h0100), rd(16'h0204), 1'b0, 1'b0);
        step("regnt", 1'b1, rd(16'h0100), rd(16'h0204), 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) step("lone_wait", 1'b1, rd(16'h0010), rd(16'h0200), 1'b0, 1'b0);
        step("force_lone", 1'b1, IDLE, rd(16'h0200), 1'b1, 1'b0);
        step("post_force", 1'b1, rd(16'h0010), rd(16'h0204), 1'b0, 1'b0);
`else
        for (int i = 0; i < 50; i++) step("starve", 1'b1, rd(16'h0010), rd(16'h0200), 1'b0, 1'b0);
        step("ext_lone", 1'b1, IDLE, rd(16'h0200), 1'b1, 1'b0);
`endif
        step("pre_rst", 1'b1, IDLE, IDLE, 1'b0, 1'b0);
        step("ext_rd_rst", 1'b0, IDLE, rd(16'h0200), 1'b1, 1'b0);
        step("post_rst", 1'b1, IDLE, IDLE, 1'b0, 1'b0);
        step("post_rst2", 1'b1, rd(16'h0010), IDLE, 1'b0, 1'b0);
        step("final_ret", 1'b1, IDLE, IDLE, 1'b0, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
